// File: rtl/id_hazard_ctrl.sv
// Decode-stage sequencing: load scoreboard, hazard stall and redirect flush.
// Outstanding loads are tracked per register; ALU results rely on forwarding.
module id_hazard_ctrl #(
  parameter int MAX_LOADS    = 4,
  parameter int FLUSH_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_valid,
  input  logic [31:0] id_instr,
  input  logic        id_wb_reg_file,
  input  logic        id_memtoreg,
  input  logic        ex_redirect,
  input  logic        wb_wr_en,
  input  logic [4:0]  wb_wr_addr,
  output logic        pc_stall,
  output logic        ifid_stall,
  output logic        idex_bubble,
  output logic        ifid_flush,
  output logic        idex_flush,
  output logic        issue,
  output logic [31:0] sb_busy,
  output logic [3:0]  load_cnt,
  output logic [15:0] stall_cycles
);

  typedef enum logic [1:0] {RUN, STALL, FLUSH} state_t;

  state_t      state, state_nxt;
  logic [2:0]  fcnt, fcnt_nxt;
  logic [31:0] busy;

  logic [6:0]  opcode;
  logic [4:0]  rd, rs1, rs2;
  logic        use_rs1, use_rs2;
  logic        hazard;
  logic        set_en, clr_en;
  logic [31:0] set_mask, clr_mask;
  logic        unused_instr;

  assign opcode       = id_instr[6:0];
  assign rd           = id_instr[11:7];
  assign rs1          = id_instr[19:15];
  assign rs2          = id_instr[24:20];
  assign unused_instr = ^{id_instr[31:25], id_instr[14:12]};

  always_comb begin
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    case (opcode)
      7'b0110011,
      7'b0100011,
      7'b1100011: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
      end
      7'b0010011,
      7'b0000011,
      7'b1100111: use_rs1 = 1'b1;
      default: ;
    endcase
  end

  // busy[0] is never set, so x0 sources and rd=x0 cannot hazard
  assign hazard = id_valid & (
      (use_rs1 & busy[rs1]) |
      (use_rs2 & busy[rs2]) |
      (id_wb_reg_file & (rd != 5'd0) & busy[rd]) |
      (id_memtoreg & (load_cnt == 4'(MAX_LOADS))));

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      fcnt  <= 3'd0;
    end else begin
      state <= state_nxt;
      fcnt  <= fcnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    fcnt_nxt  = fcnt;
    unique case (state)
      RUN, STALL: begin
        if (ex_redirect) begin
          state_nxt = FLUSH;
          fcnt_nxt  = 3'(FLUSH_CYCLES);
        end else if (hazard) begin
          state_nxt = STALL;
        end else begin
          state_nxt = RUN;
        end
      end
      FLUSH: begin
        if (ex_redirect) begin
          fcnt_nxt = 3'(FLUSH_CYCLES);
        end else if (fcnt <= 3'd1) begin
          state_nxt = RUN;
          fcnt_nxt  = 3'd0;
        end else begin
          fcnt_nxt = fcnt - 3'd1;
        end
      end
      default: state_nxt = RUN;
    endcase
  end

  always_comb begin
    pc_stall    = 1'b0;
    ifid_stall  = 1'b0;
    idex_bubble = 1'b0;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    issue       = 1'b0;
    if (rst) begin
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (state == FLUSH || ex_redirect) begin
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (hazard) begin
      pc_stall    = 1'b1;
      ifid_stall  = 1'b1;
      idex_bubble = 1'b1;
    end else begin
      issue = id_valid;
    end
  end

  assign set_en   = issue & id_memtoreg & id_wb_reg_file & (rd != 5'd0);
  assign clr_en   = wb_wr_en & busy[wb_wr_addr];
  assign set_mask = set_en ? (32'd1 << rd) : 32'd0;
  assign clr_mask = clr_en ? (32'd1 << wb_wr_addr) : 32'd0;

  // set wins over clear on the same register; the count then nets to zero
  always_ff @(posedge clk) begin
    if (rst) begin
      busy     <= 32'd0;
      load_cnt <= 4'd0;
    end else begin
      busy <= (busy & ~clr_mask) | set_mask;
      if (set_en && !clr_en && load_cnt < 4'(MAX_LOADS))
        load_cnt <= load_cnt + 4'd1;
      else if (clr_en && !set_en && load_cnt != 4'd0)
        load_cnt <= load_cnt - 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      stall_cycles <= 16'd0;
    else if (pc_stall && stall_cycles != 16'hFFFF)
      stall_cycles <= stall_cycles + 16'd1;
  end

  assign sb_busy = {busy[31:1], 1'b0};

endmodule
